// File: rtl/itrx_aib_phy_repair_pkg.sv
// Shared types and constants for the AIB repair encoder/decoder pair.
package itrx_aib_phy_repair_pkg;

    localparam int RED_W       = 45;
    localparam int SPLIT       = 23;
    localparam int TX_MIN_ONES = 2;
    localparam int MAX_ADDR    = 21;

    typedef logic [10:0] repair_word_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        EVAL = 2'd2
    } dec_state_t;

    typedef struct packed {
        logic         err;
        logic         vld;
        repair_word_t nvm;
    } dec_result_t;

    // Turns the scan accumulators into the repair word.
    // TX uses one extra engaged stage, so its address is offset by TX_MIN_ONES.
    function automatic dec_result_t decode_counts(
        input logic [4:0] tx_cnt,
        input logic [4:0] rx_cnt,
        input logic       bad
    );
        dec_result_t res;
        res = '0;
        if (tx_cnt == 5'd0 && rx_cnt == 5'd0) begin
            res = '0;
        end else if (!bad && rx_cnt == 5'd0 && tx_cnt >= 5'(TX_MIN_ONES)
                     && tx_cnt <= 5'(MAX_ADDR + TX_MIN_ONES)) begin
            res.vld = 1'b1;
            res.nvm = {1'b1, 5'd0, tx_cnt - 5'(TX_MIN_ONES)};
        end else if (!bad && tx_cnt == 5'd0 && rx_cnt <= 5'(MAX_ADDR + 1)) begin
            res.vld = 1'b1;
            res.nvm = {1'b0, 5'd0, rx_cnt - 5'd1};
        end else begin
            res.err = 1'b1;
        end
        return res;
    endfunction

endpackage

// File: rtl/itrx_aib_phy_repair_dec.sv
// Serial decoder from the 45-bit redun_engage vector back to the 11-bit repair word.
// Optional expected-value compare enabled by ITRX_AIB_PHY_REPAIR_DEC_CMP_EN.
module itrx_aib_phy_repair_dec #(
    parameter int unsigned MAXCH = 32'd1,
    parameter int          RED_W = itrx_aib_phy_repair_pkg::RED_W,
    parameter int          SPLIT = itrx_aib_phy_repair_pkg::SPLIT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [RED_W-1:0]       redun_engage,
`ifdef ITRX_AIB_PHY_REPAIR_DEC_CMP_EN
    input  logic [10:0]            exp_info,
    input  logic [0:0]             exp_vld,
    output logic                   mismatch,
`endif
    output logic                   busy,
    output logic                   done,
    output logic [MAXCH-1:0][10:0] repair_info_nvm,
    output logic [MAXCH-1:0]       repair_info_vld,
    output logic                   decode_err
);
    import itrx_aib_phy_repair_pkg::*;

    localparam logic [5:0] SPLIT_IDX = 6'(SPLIT);
    localparam logic [5:0] LAST_IDX  = 6'(RED_W - 1);

    dec_state_t       state_reg;
    logic [5:0]       idx_reg;
    logic [RED_W-1:0] snap_reg;
    logic [4:0]       tx_cnt_reg;
    logic [4:0]       rx_cnt_reg;
    logic             bad_reg;
    logic             tx_seen_reg;
    logic             rx_gap_reg;
    logic             pub_reg;
    logic             busy_reg;
    logic             done_reg;
    repair_word_t     nvm_reg;
    logic             vld_reg;
    logic             err_reg;
    logic             scan_bit;
    dec_result_t      dec;

    assign scan_bit = snap_reg[idx_reg];
    assign dec      = decode_counts(tx_cnt_reg, rx_cnt_reg, bad_reg);

`ifdef ITRX_AIB_PHY_REPAIR_DEC_CMP_EN
    repair_word_t exp_info_reg;
    logic         exp_vld_reg;
    logic         mismatch_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_info_reg <= '0;
            exp_vld_reg  <= 1'b0;
            mismatch_reg <= 1'b0;
        end else if (state_reg == IDLE && !pub_reg && start) begin
            exp_info_reg <= exp_info;
            exp_vld_reg  <= exp_vld[0];
        end else if (state_reg == EVAL) begin
            mismatch_reg <= dec.err ||
                ({dec.vld, dec.nvm} != {exp_vld_reg, exp_vld_reg ? exp_info_reg : 11'd0});
        end
    end

    assign mismatch = mismatch_reg;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            idx_reg     <= '0;
            snap_reg    <= '0;
            tx_cnt_reg  <= '0;
            rx_cnt_reg  <= '0;
            bad_reg     <= 1'b0;
            tx_seen_reg <= 1'b0;
            rx_gap_reg  <= 1'b0;
            pub_reg     <= 1'b0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
            nvm_reg     <= '0;
            vld_reg     <= 1'b0;
            err_reg     <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    // Results landed in EVAL; this cycle only retires busy and pulses done.
                    if (pub_reg) begin
                        pub_reg  <= 1'b0;
                        busy_reg <= 1'b0;
                        done_reg <= 1'b1;
                    end else if (start) begin
                        snap_reg    <= redun_engage;
                        idx_reg     <= '0;
                        tx_cnt_reg  <= '0;
                        rx_cnt_reg  <= '0;
                        bad_reg     <= 1'b0;
                        tx_seen_reg <= 1'b0;
                        rx_gap_reg  <= 1'b0;
                        busy_reg    <= 1'b1;
                        state_reg   <= SCAN;
                    end
                end
                SCAN: begin
                    // TX ones must sit at the top of [22:0]; RX ones at the bottom of [44:23].
                    if (idx_reg < SPLIT_IDX) begin
                        if (scan_bit) begin
                            tx_cnt_reg  <= tx_cnt_reg + 5'd1;
                            tx_seen_reg <= 1'b1;
                        end else if (tx_seen_reg) begin
                            bad_reg <= 1'b1;
                        end
                    end else begin
                        if (scan_bit) begin
                            rx_cnt_reg <= rx_cnt_reg + 5'd1;
                            if (rx_gap_reg) begin
                                bad_reg <= 1'b1;
                            end
                        end else begin
                            rx_gap_reg <= 1'b1;
                        end
                    end
                    if (idx_reg == LAST_IDX) begin
                        state_reg <= EVAL;
                    end else begin
                        idx_reg <= idx_reg + 6'd1;
                    end
                end
                EVAL: begin
                    nvm_reg   <= dec.nvm;
                    vld_reg   <= dec.vld;
                    err_reg   <= dec.err;
                    pub_reg   <= 1'b1;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign busy               = busy_reg;
    assign done               = done_reg;
    assign decode_err         = err_reg;
    assign repair_info_nvm[0] = nvm_reg;
    assign repair_info_vld[0] = vld_reg;

    generate
        for (genvar gi = 1; gi < MAXCH; gi++) begin : g_unused_ch
            assign repair_info_nvm[gi] = '0;
            assign repair_info_vld[gi] = 1'b0;
        end
    endgenerate

endmodule

// File: tb/tb_itrx_aib_phy_repair_dec.sv
// Self-checking bench for itrx_aib_phy_repair_dec: directed plan vectors plus random vectors
// against a shape-based reference model. Define ITRX_AIB_PHY_REPAIR_DEC_CMP_EN to cover the compare.
module tb_itrx_aib_phy_repair_dec;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [44:0]      redun_engage;
    logic             busy;
    logic             done;
    logic [0:0][10:0] repair_info_nvm;
    logic [0:0]       repair_info_vld;
    logic             decode_err;
`ifdef ITRX_AIB_PHY_REPAIR_DEC_CMP_EN
    logic [10:0]      exp_info;
    logic [0:0]       exp_vld;
    logic             mismatch;
`endif

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    itrx_aib_phy_repair_dec #(.MAXCH(1)) dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .redun_engage    (redun_engage),
`ifdef ITRX_AIB_PHY_REPAIR_DEC_CMP_EN
        .exp_info        (exp_info),
        .exp_vld         (exp_vld),
        .mismatch        (mismatch),
`endif
        .busy            (busy),
        .done            (done),
        .repair_info_nvm (repair_info_nvm),
        .repair_info_vld (repair_info_vld),
        .decode_err      (decode_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: TX field must be n ones packed at bit 22 downward, RX field n ones from bit 23 upward.
    function automatic void model(input logic [44:0] v, output logic err, output logic vld,
                                  output logic [10:0] nvm);
        int          t;
        int          r;
        logic [22:0] tf;
        logic [21:0] rf;
        logic        tx_shape;
        logic        rx_shape;
        tf = v[22:0];
        rf = v[44:23];
        t  = $countones(tf);
        r  = $countones(rf);
        tx_shape = (tf == ~(23'h7F_FFFF >> t));
        rx_shape = (rf == 22'((22'd1 << r) - 22'd1));
        err = 1'b0;
        vld = 1'b0;
        nvm = 11'd0;
        if (t == 0 && r == 0) begin
            err = 1'b0;
        end else if (r == 0 && tx_shape && t >= 2) begin
            vld = 1'b1;
            nvm = 11'h400 + 11'(t - 2);
        end else if (t == 0 && rx_shape) begin
            vld = 1'b1;
            nvm = 11'(r - 1);
        end else begin
            err = 1'b1;
        end
    endfunction

    task automatic run_decode(input logic [44:0] vec, input logic [10:0] ei, input logic ev);
        logic        m_err;
        logic        m_vld;
        logic [10:0] m_nvm;
        int          lat;
        model(vec, m_err, m_vld, m_nvm);
        @(negedge clk);
        redun_engage = vec;
        start        = 1'b1;
`ifdef ITRX_AIB_PHY_REPAIR_DEC_CMP_EN
        exp_info = ei;
        exp_vld  = ev;
`endif
        @(negedge clk);
        start        = 1'b0;
        redun_engage = {13'($urandom), $urandom};
`ifdef ITRX_AIB_PHY_REPAIR_DEC_CMP_EN
        exp_info = 11'($urandom);
        exp_vld  = 1'($urandom);
`endif
        lat = 0;
        check("busy_after_start", 32'(busy), 32'd1);
        while (!done && lat < 80) begin
            @(negedge clk);
            lat++;
        end
        check("latency", 32'(lat), 32'd47);
        check("busy_at_done", 32'(busy), 32'd0);
        check("nvm", 32'(repair_info_nvm[0]), 32'(m_nvm));
        check("vld", 32'(repair_info_vld[0]), 32'(m_vld));
        check("err", 32'(decode_err), 32'(m_err));
`ifdef ITRX_AIB_PHY_REPAIR_DEC_CMP_EN
        check("mismatch", 32'(mismatch),
              32'(m_err || ({m_vld, m_nvm} != {ev, ev ? ei : 11'd0})));
`endif
        @(negedge clk);
        check("done_pulse", 32'(done), 32'd0);
        check("hold_nvm", 32'(repair_info_nvm[0]), 32'(m_nvm));
        $display("decode vec=%h nvm=%h vld=%0d err=%0d lat=%0d", vec, repair_info_nvm[0],
                 repair_info_vld[0], decode_err, lat);
        if (ei == 11'd0 && ev) begin
            $display("note exp_info zero with exp_vld set");
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_nvm"}, 32'(repair_info_nvm[0]), 32'd0);
        check({tag, "_vld"}, 32'(repair_info_vld[0]), 32'd0);
        check({tag, "_err"}, 32'(decode_err), 32'd0);
`ifdef ITRX_AIB_PHY_REPAIR_DEC_CMP_EN
        check({tag, "_mismatch"}, 32'(mismatch), 32'd0);
`endif
    endtask

    function automatic logic [44:0] rand_vec();
        logic [44:0] v;
        int          n;
        v = '0;
        case ($urandom_range(0, 3))
            0: begin
                n = $urandom_range(0, 23);
                v[22:0] = ~(23'h7F_FFFF >> n);
            end
            1: begin
                n = $urandom_range(0, 22);
                v[44:23] = 22'((22'd1 << n) - 22'd1);
            end
            2: v = {13'($urandom), $urandom};
            default: begin
                n = $urandom_range(1, 22);
                v[44:23] = 22'((22'd1 << n) - 22'd1);
                v[$urandom_range(0, 44)] ^= 1'b1;
            end
        endcase
        return v;
    endfunction

    initial begin
        logic [44:0] vec_a;
        logic        a_err;
        logic        a_vld;
        logic [10:0] a_nvm;
        int          lat;
        int          done_cnt;
        int          done_lat;

        rst          = 1'b1;
        start        = 1'b0;
        redun_engage = '0;
`ifdef ITRX_AIB_PHY_REPAIR_DEC_CMP_EN
        exp_info = '0;
        exp_vld  = '0;
`endif
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;

        run_decode(45'h0, 11'h0, 1'b0);
        run_decode(45'h0000_0060_0000, 11'h400, 1'b1);
        check("tp_tx_min", 32'(repair_info_nvm[0]), 32'h400);
        run_decode(45'h0000_007F_FFFF, 11'h415, 1'b1);
        check("tp_tx_max", 32'(repair_info_nvm[0]), 32'h415);
        run_decode(45'h0000_0080_0000, 11'h000, 1'b1);
        check("tp_rx_min", 32'(repair_info_nvm[0]), 32'h000);
        check("tp_rx_min_vld", 32'(repair_info_vld[0]), 32'd1);
        run_decode(45'h1FFF_FF80_0000, 11'h015, 1'b1);
        check("tp_rx_max", 32'(repair_info_nvm[0]), 32'h015);
        run_decode(45'h0000_0040_0000, 11'h0, 1'b0);
        check("tp_tx_one", 32'(decode_err), 32'd1);
        run_decode(45'h0000_0180_0001, 11'h0, 1'b0);
        check("tp_both", 32'(decode_err), 32'd1);
        run_decode(45'h0000_0050_0000, 11'h0, 1'b0);
        check("tp_gap", 32'(decode_err), 32'd1);
        check("tp_gap_vld", 32'(repair_info_vld[0]), 32'd0);

`ifdef ITRX_AIB_PHY_REPAIR_DEC_CMP_EN
        run_decode(45'h0000_007C_0000, 11'h403, 1'b1);
        check("tp_cmp_match", 32'(mismatch), 32'd0);
        run_decode(45'h0000_007C_0000, 11'h404, 1'b1);
        check("tp_cmp_diff", 32'(mismatch), 32'd1);
`endif

        // Disturbances during a decode: input change at 5, extra start at 10.
        vec_a = 45'h0000_0078_0000;
        model(vec_a, a_err, a_vld, a_nvm);
        @(negedge clk);
        redun_engage = vec_a;
        start        = 1'b1;
`ifdef ITRX_AIB_PHY_REPAIR_DEC_CMP_EN
        exp_info = a_nvm;
        exp_vld  = 1'b1;
`endif
        @(negedge clk);
        start    = 1'b0;
        lat      = 0;
        done_cnt = 0;
        done_lat = -1;
        while (lat < 110) begin
            @(negedge clk);
            lat++;
            if (done) begin
                done_cnt++;
                done_lat = lat;
            end
            if (lat == 5) redun_engage = 45'h1FFF_FFFF_FFFF;
            start = (lat == 10);
        end
        check("disturb_done_count", 32'(done_cnt), 32'd1);
        check("disturb_done_lat", 32'(done_lat), 32'd47);
        check("disturb_nvm", 32'(repair_info_nvm[0]), 32'(a_nvm));
        check("disturb_vld", 32'(repair_info_vld[0]), 32'(a_vld));
        $display("disturb vec=%h nvm=%h dones=%0d", vec_a, repair_info_nvm[0], done_cnt);

        // Reset partway through a second decode.
        @(negedge clk);
        redun_engage = 45'h0000_0080_0000;
        start        = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        rst = 1'b1;
        #1;
        check_all_zero("async_rst");
        @(negedge clk);
        rst      = 1'b0;
        done_cnt = 0;
        repeat (60) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
        check("rst_no_done", 32'(done_cnt), 32'd0);
        check_all_zero("after_rst");
        $display("reset-abort dones=%0d nvm=%h", done_cnt, repair_info_nvm[0]);

        run_decode(45'h0000_0060_0000, 11'h400, 1'b1);

        for (int i = 0; i < 30; i++) begin
            logic [44:0] v;
            logic        m_err;
            logic        m_vld;
            logic [10:0] m_nvm;
            v = rand_vec();
            model(v, m_err, m_vld, m_nvm);
            if ($urandom_range(0, 1) == 0) begin
                run_decode(v, m_nvm, m_vld);
            end else begin
                run_decode(v, 11'($urandom), 1'($urandom));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
